// File: rtl/demux_1_8_struct_pkg.sv
// Shared sizing constants for the demux/mux family.
//   SEL_W : number of select bits
//   N_OUT : number of routed outputs (2**SEL_W)
package demux_1_8_struct_pkg;
  localparam int SEL_W = 3;
  localparam int N_OUT = 8;
endpackage

// File: rtl/demux_1_2_cell.sv
// Gate-level 1-to-2 demultiplexer cell, the building block of the demux tree.
// Ports:
//   d  : data in
//   s  : select
//   y0 : d routed when s = 0
//   y1 : d routed when s = 1
module demux_1_2_cell (
  input  logic d,
  input  logic s,
  output logic y0,
  output logic y1
);
  logic s_n;

  not u_inv (s_n, s);
  and u_a0  (y0, d, s_n);
  and u_a1  (y1, d, s);
endmodule

// File: rtl/demux_1_8_struct.sv
// Registered 1-to-8 demultiplexer: a three-level tree of 1-to-2 demux cells
// routes A to the output chosen by {S3,S2,S1}; results are captured in eight
// flops with asynchronous active-low clear (one-cycle routing stage).
// Ports:
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset, clears all outputs
//   S3,S2,S1   : select, S3 is the MSB
//   A          : data bit to route
//   Y1..Y8     : registered outputs, Y(n+1) is selected by value n
module demux_1_8_struct
  import demux_1_8_struct_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic S3,
  input  logic S2,
  input  logic S1,
  input  logic A,
  output logic Y1,
  output logic Y2,
  output logic Y3,
  output logic Y4,
  output logic Y5,
  output logic Y6,
  output logic Y7,
  output logic Y8
);
  logic [1:0]       l1;
  logic [3:0]       l2;
  logic [N_OUT-1:0] y_d;
  logic [N_OUT-1:0] y_q;

  // Level 1 splits on the MSB: l1[0] carries sel 0..3, l1[1] carries sel 4..7.
  demux_1_2_cell u_l1 (.d(A), .s(S3), .y0(l1[0]), .y1(l1[1]));

  // Level 2 splits each half on S2; l2[i] carries sel {S3,S2} == i.
  demux_1_2_cell u_l2_0 (.d(l1[0]), .s(S2), .y0(l2[0]), .y1(l2[1]));
  demux_1_2_cell u_l2_1 (.d(l1[1]), .s(S2), .y0(l2[2]), .y1(l2[3]));

  // Level 3 splits on S1; leaf index equals the full select value.
  for (genvar i = 0; i < 4; i++) begin : g_l3
    demux_1_2_cell u_l3 (.d(l2[i]), .s(S1), .y0(y_d[2*i]), .y1(y_d[2*i+1]));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q <= '0;
    end else begin
      y_q <= y_d;
    end
  end

  assign Y1 = y_q[0];
  assign Y2 = y_q[1];
  assign Y3 = y_q[2];
  assign Y4 = y_q[3];
  assign Y5 = y_q[4];
  assign Y6 = y_q[5];
  assign Y7 = y_q[6];
  assign Y8 = y_q[7];
endmodule

// File: tb/tb_demux_1_8_struct.sv
// Scoreboard bench for demux_1_8_struct: the driver pushes the expected output
// for each upcoming edge, the monitor pops and compares after every edge.
module tb_demux_1_8_struct;
  logic clk = 1'b0;
  logic rst_n;
  logic S3, S2, S1, A;
  logic Y1, Y2, Y3, Y4, Y5, Y6, Y7, Y8;
  logic [7:0] y_obs;

  logic [7:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  demux_1_8_struct dut (
    .clk(clk), .rst_n(rst_n),
    .S3(S3), .S2(S2), .S1(S1), .A(A),
    .Y1(Y1), .Y2(Y2), .Y3(Y3), .Y4(Y4),
    .Y5(Y5), .Y6(Y6), .Y7(Y7), .Y8(Y8)
  );

  assign y_obs = {Y8, Y7, Y6, Y5, Y4, Y3, Y2, Y1};

  // Reference: output number sel+1 carries A, everything else is low.
  function automatic logic [7:0] model(input bit a, input bit [2:0] s);
    logic [7:0] r;
    r = 8'h00;
    if (a) r[s] = 1'b1;
    return r;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  // Drive new inputs on the falling edge and record what the next rising edge must produce.
  task automatic drive(input bit a, input bit [2:0] s);
    @(negedge clk);
    A = a;
    {S3, S2, S1} = s;
    exp_q.push_back(rst_n ? model(a, s) : 8'h00);
  endtask

  // Monitor: compare after every rising edge that has an expectation pending.
  initial begin
    logic [7:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("route", y_obs, e);
        chk("onehot", {7'd0, ($countones(y_obs) <= 1)}, 8'd1);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    A = 1'b1;
    {S3, S2, S1} = 3'b101;
    #1;
    chk("reset_no_clock", y_obs, 8'h00);

    // Held in reset with A=1, sel=101: outputs stay low.
    repeat (3) drive(1'b1, 3'd5);
    @(posedge clk);
    #2 rst_n = 1'b1;
    drive(1'b1, 3'd5);

    // Select sweep with A=1, then A=0.
    for (int s = 0; s < 8; s++) repeat (2) drive(1'b1, 3'(s));
    for (int s = 0; s < 8; s++) repeat (2) drive(1'b0, 3'(s));

    // Latency / handover: Y4 then Y7 on consecutive edges.
    drive(1'b0, 3'd0);
    drive(1'b1, 3'd3);
    drive(1'b1, 3'd6);

    // Async reset pulse between edges while Y8 is high.
    drive(1'b1, 3'd7);
    drive(1'b1, 3'd7);
    chk("y8_before_pulse", y_obs, 8'h80);
    #2 rst_n = 1'b0;
    #1 chk("async_clear", y_obs, 8'h00);
    #1 rst_n = 1'b1;
    drive(1'b1, 3'd7);

    // sel and A change together.
    drive(1'b1, 3'd0);
    drive(1'b0, 3'd7);

    // Randomised traffic.
    for (int i = 0; i < 200; i++) drive(1'($urandom), 3'($urandom_range(7, 0)));

    @(posedge clk);
    #2;
    chk("scoreboard_drained", 8'(exp_q.size()), 8'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
